logic_core: RTL and testbench

- Command-driven 9-tap convolution (dot-product) engine for the ConvFPGA datapath.
- Consumes 24-bit command words from an external host port via `master_bus`.
- Keeps 9 signed weights and a 9-deep pixel shift window.
- Emits one registered result per pixel once the window is full.
- The host-side port emulator is a bench model and is not part of this block.

---
 rtl/logic_pkg.sv | 42 ++++
 rtl/conv_mac.sv | 34 +++
 rtl/logic_core.sv | 115 +++++++++++
 tb/tb_logic_core.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared constants and command-word decoding for the 9-tap convolution engine.
package logic_pkg;

   localparam int TAPS_DEF   = 9;
   localparam int DATA_W_DEF = 8;
   localparam int ACC_W_DEF  = 20;

   localparam int BUS_W     = 24;
   localparam int VALID_BIT = 23;
   localparam int TAG_BIT   = 22;
   localparam int OP_HI     = 21;
   localparam int OP_LO     = 18;
   localparam int IDX_HI    = 17;
   localparam int IDX_LO    = 14;
   localparam int DATA_HI   = 7;
   localparam int DATA_LO   = 0;

   localparam logic [3:0] OP_NOP        = 4'd0;
   localparam logic [3:0] OP_SET_WEIGHT = 4'd1;
   localparam logic [3:0] OP_PUSH_PIXEL = 4'd2;
   localparam logic [3:0] OP_CLEAR      = 4'd3;
   localparam logic [3:0] OP_SET_SHIFT  = 4'd4;

   typedef struct packed {
      logic       vld;
      logic       tag;
      logic [3:0] op;
      logic [3:0] idx;
      logic [7:0] data;
   } cmd_t;

   function automatic cmd_t decode_cmd(input logic [BUS_W-1:0] bus);
      cmd_t c;
      c.vld  = bus[VALID_BIT];
      c.tag  = bus[TAG_BIT];
      c.op   = bus[OP_HI:OP_LO];
      c.idx  = bus[IDX_HI:IDX_LO];
      c.data = bus[DATA_HI:DATA_LO];
      return c;
   endfunction

endpackage

// File: rtl/conv_mac.sv
// Combinational 9-way signed x unsigned multiply-add tree with arithmetic output shift.
module conv_mac
   import logic_pkg::*;
#(
   parameter int TAPS   = TAPS_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic signed [DATA_W-1:0] weight_i [TAPS],
   input  logic        [DATA_W-1:0] pixel_i  [TAPS],
   input  logic        [3:0]        shift_i,
   output logic signed [ACC_W-1:0]  sum_o
);

   logic signed [2*DATA_W:0] prod;
   logic signed [ACC_W-1:0]  acc;

   // Floor division by 2^sh; no saturation, the accumulator is sized for the worst case.
   function automatic logic signed [ACC_W-1:0] asr_floor(input logic signed [ACC_W-1:0] v,
                                                          input logic [3:0] sh);
      return v >>> sh;
   endfunction

   always_comb begin
      prod = '0;
      acc  = '0;
      for (int k = 0; k < TAPS; k++) begin
         prod = weight_i[k] * $signed({1'b0, pixel_i[k]});
         acc  = acc + ACC_W'(prod);
      end
      sum_o = asr_floor(acc, shift_i);
   end

endmodule

// File: rtl/logic_core.sv
// Command-driven 9-tap convolution engine: tag-toggle command acceptance, weight/window
// state, and a registered dot-product result one edge after the completing pixel push.
module logic_core
   import logic_pkg::*;
#(
   parameter int TAPS   = TAPS_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int ACC_W  = ACC_W_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [BUS_W-1:0]        master_bus,
   output logic signed [ACC_W-1:0] result,
   output logic                    result_valid,
   output logic                    error
);

   localparam logic [3:0] FULL = 4'(TAPS);

   cmd_t cmd;
   logic accept;
   logic rsvd_unused;

   logic signed [DATA_W-1:0] weight_q [TAPS];
   logic signed [DATA_W-1:0] weight_d [TAPS];
   logic        [DATA_W-1:0] win_q    [TAPS];
   logic        [DATA_W-1:0] win_d    [TAPS];
   logic [3:0]               fill_q, fill_d;
   logic [3:0]               shift_q, shift_d;
   logic                     tag_q, tag_d;
   logic                     fire_q, fire_d;
   logic                     err_q, err_d;
   logic signed [ACC_W-1:0]  result_q, result_d;
   logic                     valid_q, valid_d;
   logic signed [ACC_W-1:0]  mac_sum;

   assign rsvd_unused = ^master_bus[13:8];

   conv_mac #(
      .TAPS   (TAPS),
      .DATA_W (DATA_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .weight_i (weight_q),
      .pixel_i  (win_q),
      .shift_i  (shift_q),
      .sum_o    (mac_sum)
   );

   always_comb begin
      cmd      = decode_cmd(master_bus);
      accept   = cmd.vld && (cmd.tag != tag_q);
      weight_d = weight_q;
      win_d    = win_q;
      fill_d   = fill_q;
      shift_d  = shift_q;
      tag_d    = tag_q;
      fire_d   = 1'b0;
      err_d    = err_q;
      if (accept) begin
         tag_d = cmd.tag;
         case (cmd.op)
            OP_NOP: ;
            OP_SET_WEIGHT: begin
               if (cmd.idx < FULL) weight_d[cmd.idx] = $signed(cmd.data);
               else                err_d = 1'b1;
            end
            OP_PUSH_PIXEL: begin
               for (int k = TAPS - 1; k > 0; k--) win_d[k] = win_q[k-1];
               win_d[0] = cmd.data;
               fill_d   = (fill_q == FULL) ? fill_q : fill_q + 4'd1;
               fire_d   = (fill_d == FULL);
            end
            OP_CLEAR: begin
               win_d  = '{default: '0};
               fill_d = '0;
            end
            OP_SET_SHIFT: shift_d = cmd.data[3:0];
            default:      err_d = 1'b1;
         endcase
      end
      // Result stage samples state before this edge's command, so in-flight sums keep old coefficients.
      result_d = fire_q ? mac_sum : result_q;
      valid_d  = fire_q;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         weight_q <= '{default: '0};
         win_q    <= '{default: '0};
         fill_q   <= '0;
         shift_q  <= '0;
         tag_q    <= 1'b0;
         fire_q   <= 1'b0;
         err_q    <= 1'b0;
         result_q <= '0;
         valid_q  <= 1'b0;
      end else begin
         weight_q <= weight_d;
         win_q    <= win_d;
         fill_q   <= fill_d;
         shift_q  <= shift_d;
         tag_q    <= tag_d;
         fire_q   <= fire_d;
         err_q    <= err_d;
         result_q <= result_d;
         valid_q  <= valid_d;
      end
   end

   assign result       = result_q;
   assign result_valid = valid_q;
   assign error        = err_q;

endmodule

// File: tb/tb_logic_core.sv
// Scoreboard bench for logic_core: a behavioural model queues expected results at push time.
module tb_logic_core;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic [23:0]        master_bus = '0;
   logic signed [19:0] result;
   logic               result_valid;
   logic               error;

   int total = 0;
   int bad   = 0;

   int          m_w   [9];
   int          m_win [9];
   int          m_fill;
   int          m_shift;
   logic        tag;
   logic [19:0] sbq [$];
   int          nvalid = 0;
   logic [19:0] last_res;

   logic_core dut (
      .clk          (clk),
      .rst          (rst_n),
      .master_bus   (master_bus),
      .result       (result),
      .result_valid (result_valid),
      .error        (error)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      for (int k = 0; k < 9; k++) begin
         m_w[k]   = 0;
         m_win[k] = 0;
      end
      m_fill  = 0;
      m_shift = 0;
      tag     = 1'b0;
      sbq.delete();
   endtask

   task automatic model_apply(input logic [3:0] op, input logic [3:0] idx, input logic [7:0] data);
      int s;
      case (op)
         4'd1: if (idx < 9) m_w[idx] = int'($signed(data));
         4'd2: begin
            for (int k = 8; k > 0; k--) m_win[k] = m_win[k-1];
            m_win[0] = int'(data);
            if (m_fill < 9) m_fill++;
            if (m_fill == 9) begin
               s = 0;
               for (int k = 0; k < 9; k++) s += m_w[k] * m_win[k];
               s = s >>> m_shift;
               sbq.push_back(s[19:0]);
            end
         end
         4'd3: begin
            for (int k = 0; k < 9; k++) m_win[k] = 0;
            m_fill = 0;
         end
         4'd4: m_shift = int'(data[3:0]);
         default: ;
      endcase
   endtask

   task automatic tick();
      logic [19:0] exp;
      @(posedge clk);
      #1;
      if (result_valid === 1'b1) begin
         nvalid++;
         total++;
         last_res = result;
         if (sbq.size() == 0) begin
            bad++;
            $display("FAIL unexpected_valid: result=%h valid=1 required valid=0", result);
         end else begin
            exp = sbq.pop_front();
            if (result !== exp) begin
               bad++;
               $display("FAIL scoreboard_result: got=%h required=%h", result, exp);
            end
         end
      end
   endtask

   task automatic send(input logic [3:0] op, input logic [3:0] idx, input logic [7:0] data);
      tag = ~tag;
      master_bus = {1'b1, tag, op, idx, 6'b0, data};
      model_apply(op, idx, data);
      tick();
      master_bus[23] = 1'b0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      master_bus = '0;
      model_reset();
      #2;
   endtask

   task automatic release_reset();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic check_drained(input string name);
      tick();
      tick();
      total++;
      if (sbq.size() != 0) begin
         bad++;
         $display("FAIL %s_pending: outstanding=%0d required=0", name, sbq.size());
      end
   endtask

   task automatic test_reset();
      do_reset();
      total++;
      if (result !== 20'h0) begin bad++; $display("FAIL reset_result: got=%h required=0", result); end
      total++;
      if (result_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got=%b required=0", result_valid); end
      total++;
      if (error !== 1'b0) begin bad++; $display("FAIL reset_error: got=%b required=0", error); end
      release_reset();
      tick();
   endtask

   task automatic test_basic();
      int n0;
      for (int k = 0; k < 9; k++) send(4'd1, 4'(k), 8'd1);
      send(4'd4, 4'd0, 8'd0);
      n0 = nvalid;
      for (int p = 1; p <= 9; p++) send(4'd2, 4'd0, 8'(p));
      total++;
      if (nvalid !== n0) begin bad++; $display("FAIL basic_early_valid: got=%0d required=%0d", nvalid, n0); end
      tick();
      total++;
      if (nvalid !== n0 + 1 || last_res !== 20'd45) begin
         bad++; $display("FAIL basic_sum45: valids=%0d res=%0d required valids=%0d res=45", nvalid - n0, last_res, 1);
      end
      tick();
      total++;
      if (result_valid !== 1'b0) begin bad++; $display("FAIL basic_pulse_width: got=%b required=0", result_valid); end
      send(4'd2, 4'd0, 8'd10);
      tick();
      total++;
      if (nvalid !== n0 + 2 || last_res !== 20'd54) begin
         bad++; $display("FAIL basic_sum54: valids=%0d res=%0d required valids=2 res=54", nvalid - n0, last_res);
      end
      check_drained("basic");
   endtask

   task automatic test_hold();
      int n0;
      n0 = nvalid;
      tag = ~tag;
      master_bus = {1'b1, tag, 4'd2, 4'd0, 6'b0, 8'd11};
      model_apply(4'd2, 4'd0, 8'd11);
      repeat (5) tick();
      master_bus[23] = 1'b0;
      tick();
      total++;
      if (nvalid !== n0 + 1) begin bad++; $display("FAIL hold_once: valids=%0d required=1", nvalid - n0); end
      total++;
      if (last_res !== 20'd63) begin bad++; $display("FAIL hold_sum: got=%0d required=63", last_res); end
      check_drained("hold");
   endtask

   task automatic test_negative();
      send(4'd3, 4'd0, 8'd0);
      for (int k = 0; k < 9; k++) send(4'd1, 4'(k), 8'd0);
      send(4'd1, 4'd0, 8'hFF);
      send(4'd2, 4'd0, 8'd255);
      for (int i = 0; i < 8; i++) send(4'd2, 4'd0, 8'd0);
      tick();
      total++;
      if (last_res !== 20'h0) begin bad++; $display("FAIL neg_w0: got=%h required=00000", last_res); end
      send(4'd3, 4'd0, 8'd0);
      send(4'd1, 4'd0, 8'd0);
      send(4'd1, 4'd8, 8'hFF);
      send(4'd2, 4'd0, 8'd255);
      for (int i = 0; i < 8; i++) send(4'd2, 4'd0, 8'd0);
      tick();
      total++;
      if (last_res !== 20'hFFF01) begin bad++; $display("FAIL neg_w8: got=%h required=fff01", last_res); end
      send(4'd4, 4'd0, 8'd4);
      send(4'd3, 4'd0, 8'd0);
      send(4'd2, 4'd0, 8'd255);
      for (int i = 0; i < 8; i++) send(4'd2, 4'd0, 8'd0);
      tick();
      total++;
      if (last_res !== 20'hFFFF0) begin bad++; $display("FAIL neg_shift4: got=%h required=ffff0", last_res); end
      check_drained("negative");
   endtask

   task automatic test_error();
      total++;
      if (error !== 1'b0) begin bad++; $display("FAIL err_initial: got=%b required=0", error); end
      send(4'd1, 4'd9, 8'd5);
      total++;
      if (error !== 1'b1) begin bad++; $display("FAIL err_index9: got=%b required=1", error); end
      send(4'd7, 4'd1, 8'd5);
      tick();
      total++;
      if (error !== 1'b1) begin bad++; $display("FAIL err_sticky: got=%b required=1", error); end
      send(4'd4, 4'd0, 8'd0);
      send(4'd3, 4'd0, 8'd0);
      for (int p = 1; p <= 9; p++) send(4'd2, 4'd0, 8'(p));
      tick();
      total++;
      if (last_res !== 20'hFFFFF) begin bad++; $display("FAIL err_weights_kept: got=%h required=fffff", last_res); end
      check_drained("error");
   endtask

   task automatic test_clear();
      int n0;
      for (int k = 0; k < 9; k++) send(4'd1, 4'(k), 8'(k - 4));
      send(4'd4, 4'd0, 8'd1);
      for (int p = 0; p < 5; p++) send(4'd2, 4'd0, 8'(200 + p));
      send(4'd3, 4'd0, 8'd0);
      n0 = nvalid;
      for (int p = 0; p < 8; p++) send(4'd2, 4'd0, 8'(10 * p + 3));
      tick();
      total++;
      if (nvalid !== n0) begin bad++; $display("FAIL clear_no_valid: valids=%0d required=0", nvalid - n0); end
      send(4'd2, 4'd0, 8'd250);
      tick();
      total++;
      if (nvalid !== n0 + 1) begin bad++; $display("FAIL clear_ninth: valids=%0d required=1", nvalid - n0); end
      check_drained("clear");
   endtask

   task automatic test_back_to_back();
      int n0;
      n0 = nvalid;
      send(4'd2, 4'd0, 8'd17);
      send(4'd2, 4'd0, 8'd99);
      send(4'd2, 4'd0, 8'd128);
      send(4'd1, 4'd0, 8'h80);
      send(4'd4, 4'd0, 8'd0);
      send(4'd2, 4'd0, 8'd255);
      tick();
      total++;
      if (nvalid !== n0 + 4) begin bad++; $display("FAIL b2b_count: valids=%0d required=4", nvalid - n0); end
      check_drained("b2b");
   endtask

   task automatic test_reset_midstream();
      int n0;
      for (int k = 0; k < 9; k++) send(4'd1, 4'(k), 8'd2);
      for (int p = 0; p < 9; p++) send(4'd2, 4'd0, 8'd7);
      do_reset();
      total++;
      if (result !== 20'h0 || result_valid !== 1'b0 || error !== 1'b0) begin
         bad++; $display("FAIL midreset_state: res=%h vld=%b err=%b required 0 0 0", result, result_valid, error);
      end
      release_reset();
      tick();
      total++;
      if (result_valid !== 1'b0) begin bad++; $display("FAIL midreset_discard: got=%b required=0", result_valid); end
      for (int k = 0; k < 9; k++) send(4'd1, 4'(k), 8'd1);
      n0 = nvalid;
      for (int p = 0; p < 8; p++) send(4'd2, 4'd0, 8'd3);
      tick();
      total++;
      if (nvalid !== n0) begin bad++; $display("FAIL midreset_refill: valids=%0d required=0", nvalid - n0); end
      send(4'd2, 4'd0, 8'd3);
      tick();
      total++;
      if (nvalid !== n0 + 1 || last_res !== 20'd27) begin
         bad++; $display("FAIL midreset_sum: valids=%0d res=%0d required valids=1 res=27", nvalid - n0, last_res);
      end
      check_drained("midreset");
   endtask

   initial begin
      model_reset();
      test_reset();
      test_basic();
      test_hold();
      test_negative();
      test_error();
      test_clear();
      test_back_to_back();
      test_reset_midstream();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
